// File: rtl/pll_drp_pkg.sv
// Shared definitions for the PLLE2 DRP reconfiguration controller:
// FSM states, DRP address map, keep masks and divide-to-register encoding.
package pll_drp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        NEXT,
        RST_WAIT,
        LOCK_WAIT
    } state_t;

    localparam logic [15:0] KEEP_MASK_REG1 = 16'hF000;
    localparam logic [15:0] KEEP_MASK_REG2 = 16'hFF3F;

    // REG1 address per CLKOUT index; REG2 always sits at REG1+1. Entries 6/7 are padding.
    localparam logic [6:0] DRP_REG1_ADDR [0:7] = '{
        7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h10, 7'h06, 7'h00, 7'h00
    };

    // Unity divide uses the fixed 1/1 count with nocount set and edge clear.
    // A low count of 64 (divide 127) wraps to 0, which the counter reads as 64.
    function automatic logic [15:0] div_to_reg(input logic [6:0] div, input logic regsel);
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_bit;
        logic       nocount;
        if (div == 7'd1) begin
            high     = 6'd1;
            low      = 6'd1;
            edge_bit = 1'b0;
            nocount  = 1'b1;
        end else begin
            high     = div[6:1];
            low      = 6'(div - {1'b0, high});
            edge_bit = div[0];
            nocount  = 1'b0;
        end
        if (regsel)
            return {8'h00, edge_bit, nocount, 6'h00};
        return {4'h0, high, low};
    endfunction

endpackage

// File: rtl/pll_drp_reconfig_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_drp_reconfig.sv
// Runtime CLKOUT divider rewrite for a PLLE2_ADV over DRP, including the
// PLL reset/lock sequencing used both at power-on and after each rewrite.
module pll_drp_reconfig
    import pll_drp_pkg::*;
#(
    parameter int NUM_OUT      = 4,
    parameter int RST_HOLD     = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [NUM_OUT-1:0]     cfg_en,
    input  logic [7*NUM_OUT-1:0]   cfg_div,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   pll_locked_ok,
    output logic                   pll_rst,
    input  logic                   pll_locked,
    output logic [6:0]             daddr,
    output logic                   den,
    output logic                   dwe,
    output logic [15:0]            di,
    input  logic [15:0]            dout,
    input  logic                   drdy
);

    localparam int TMAX_A = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
    localparam int TMAX   = (LOCK_TIMEOUT > TMAX_A) ? LOCK_TIMEOUT : TMAX_A;
    localparam int TW     = $clog2(TMAX + 1);

    state_t               state, state_nxt;
    logic [NUM_OUT-1:0]   en_q, en_nxt;
    logic [7*NUM_OUT-1:0] div_q, div_nxt;
    logic [2:0]           idx, idx_nxt;
    logic                 reg_sel, reg_sel_nxt;
    logic [15:0]          rd_data, rd_data_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic                 pll_rst_nxt;
    logic                 done_nxt, err_nxt;
    logic                 healthy, healthy_nxt;
    logic                 lock_sync;

    logic                 any_zero;
    logic                 first_found, next_found;
    logic [2:0]           first_idx, next_idx;
    logic [6:0]           cur_div;
    logic [6:0]           cur_addr;
    logic [15:0]          wr_data;

    sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_sync)
    );

    // Descending scan so the lowest enabled index wins for both first and next.
    always_comb begin
        any_zero    = 1'b0;
        first_found = 1'b0;
        first_idx   = 3'd0;
        next_found  = 1'b0;
        next_idx    = 3'd0;
        cur_div     = 7'd0;
        for (int n = NUM_OUT - 1; n >= 0; n--) begin
            if (idx == 3'(n))
                cur_div = div_q[7*n +: 7];
            if (en_q[n]) begin
                if (div_q[7*n +: 7] == 7'd0)
                    any_zero = 1'b1;
                first_found = 1'b1;
                first_idx   = 3'(n);
                if (3'(n) > idx) begin
                    next_found = 1'b1;
                    next_idx   = 3'(n);
                end
            end
        end
    end

    assign cur_addr = reg_sel ? (DRP_REG1_ADDR[idx] + 7'd1) : DRP_REG1_ADDR[idx];
    assign wr_data  = (rd_data & (reg_sel ? KEEP_MASK_REG2 : KEEP_MASK_REG1))
                    | div_to_reg(cur_div, reg_sel);

    assign cfg_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign den           = (state == RD) || (state == WR);
    assign dwe           = (state == WR);
    assign daddr         = (state == RD || state == RD_WAIT || state == WR || state == WR_WAIT)
                           ? cur_addr : 7'd0;
    assign di            = (state == WR) ? wr_data : 16'h0000;
    assign pll_locked_ok = lock_sync && (state == IDLE) && healthy;

    always_comb begin
        state_nxt   = state;
        en_nxt      = en_q;
        div_nxt     = div_q;
        idx_nxt     = idx;
        reg_sel_nxt = reg_sel;
        rd_data_nxt = rd_data;
        timer_nxt   = timer;
        pll_rst_nxt = pll_rst;
        healthy_nxt = healthy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    en_nxt    = cfg_en;
                    div_nxt   = cfg_div;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (any_zero) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (!first_found) begin
                    // A PLL still held in reset after a failure must be re-sequenced.
                    if (pll_rst) begin
                        healthy_nxt = 1'b0;
                        timer_nxt   = '0;
                        state_nxt   = RST_WAIT;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    pll_rst_nxt = 1'b1;
                    healthy_nxt = 1'b0;
                    idx_nxt     = first_idx;
                    reg_sel_nxt = 1'b0;
                    state_nxt   = RD;
                end
            end
            RD: begin
                timer_nxt = '0;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (drdy) begin
                    rd_data_nxt = dout;
                    state_nxt   = WR;
                end else if (timer == TW'(DRDY_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WR: begin
                timer_nxt = '0;
                state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (drdy) begin
                    state_nxt = NEXT;
                end else if (timer == TW'(DRDY_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            NEXT: begin
                if (!reg_sel) begin
                    reg_sel_nxt = 1'b1;
                    state_nxt   = RD;
                end else if (next_found) begin
                    idx_nxt     = next_idx;
                    reg_sel_nxt = 1'b0;
                    state_nxt   = RD;
                end else begin
                    timer_nxt = '0;
                    state_nxt = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (timer == TW'(RST_HOLD - 1)) begin
                    pll_rst_nxt = 1'b0;
                    timer_nxt   = '0;
                    state_nxt   = LOCK_WAIT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            LOCK_WAIT: begin
                if (lock_sync) begin
                    done_nxt    = 1'b1;
                    healthy_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    err_nxt     = 1'b1;
                    pll_rst_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state   <= RST_WAIT;
            en_q    <= '0;
            div_q   <= '0;
            idx     <= 3'd0;
            reg_sel <= 1'b0;
            rd_data <= 16'h0000;
            timer   <= '0;
            pll_rst <= 1'b1;
            healthy <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            en_q    <= en_nxt;
            div_q   <= div_nxt;
            idx     <= idx_nxt;
            reg_sel <= reg_sel_nxt;
            rd_data <= rd_data_nxt;
            timer   <= timer_nxt;
            pll_rst <= pll_rst_nxt;
            healthy <= healthy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Self-checking bench for pll_drp_reconfig with a behavioural DRP RAM,
// a PLL lock model and a spec-level model of the expected DRP contents.
module tb_pll_drp_reconfig;

    localparam int NUM_OUT      = 4;
    localparam int RST_HOLD     = 16;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TO      = 1000;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_en = 4'h0;
    logic [27:0] cfg_div = 28'h0;
    logic        busy, done, err, pll_locked_ok, pll_rst;
    logic        pll_locked = 1'b0;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di;
    logic [15:0] dout = 16'h0;
    logic        drdy = 1'b0;

    int checks = 0;
    int failures = 0;

    pll_drp_reconfig #(
        .NUM_OUT      (NUM_OUT),
        .RST_HOLD     (RST_HOLD),
        .DRDY_TIMEOUT (DRDY_TIMEOUT),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_en        (cfg_en),
        .cfg_div       (cfg_div),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .pll_locked_ok (pll_locked_ok),
        .pll_rst       (pll_rst),
        .pll_locked    (pll_locked),
        .daddr         (daddr),
        .den           (den),
        .dwe           (dwe),
        .di            (di),
        .dout          (dout),
        .drdy          (drdy)
    );

    always #5 refclk = ~refclk;

    // DRP model: 64x16 RAM, drdy two cycles after den; can be told to withhold drdy.
    logic [15:0] ram      [0:63];
    logic [15:0] ram_init [0:63];
    logic [15:0] ram_exp  [0:63];
    logic        load_ram = 1'b0;
    logic        drdy_enable = 1'b1;
    int          acc_cnt = 0;
    logic [5:0]  acc_addr = 6'd0;
    logic        acc_we = 1'b0;
    logic [15:0] acc_di = 16'h0;
    int          den_count = 0;

    always @(posedge refclk) begin
        drdy <= 1'b0;
        if (load_ram)
            for (int i = 0; i < 64; i++) ram[i] <= ram_init[i];
        if (acc_cnt == 1 && drdy_enable) begin
            drdy <= 1'b1;
            dout <= ram[acc_addr];
            if (acc_we) ram[acc_addr] <= acc_di;
        end
        if (acc_cnt != 0) acc_cnt <= acc_cnt - 1;
        if (den) begin
            acc_cnt   <= 2;
            acc_addr  <= daddr[5:0];
            acc_we    <= dwe;
            acc_di    <= di;
            den_count <= den_count + 1;
        end
    end

    // Lock model: LOCKED rises 100 cycles after RST falls, unless withheld.
    logic lock_enable = 1'b1;
    int   lock_cnt = 0;

    always @(posedge refclk) begin
        if (pll_rst) begin
            pll_locked <= 1'b0;
            lock_cnt   <= 0;
        end else if (lock_cnt < 100) begin
            lock_cnt <= lock_cnt + 1;
        end else begin
            pll_locked <= lock_enable;
        end
    end

    int reg1_addr [0:3] = '{8, 10, 12, 14};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoding from the divide rules: high=D/2, low=D-high (64 wraps to 0).
    function automatic logic [15:0] exp_reg1(input int d);
        int hi, lo;
        if (d == 1) return 16'h0041;
        hi = d / 2;
        lo = d - hi;
        return 16'((hi << 6) | (lo % 64));
    endfunction

    function automatic logic [15:0] exp_reg2(input int d);
        if (d == 1) return 16'h0040;
        return 16'((d % 2) << 7);
    endfunction

    task automatic model_apply(input logic [3:0] en, input logic [27:0] div);
        int d, a;
        for (int n = 0; n < NUM_OUT; n++) begin
            if (en[n]) begin
                d = int'(div[7*n +: 7]);
                a = reg1_addr[n];
                ram_exp[a]   = (ram_exp[a] & 16'hF000) | exp_reg1(d);
                ram_exp[a+1] = (ram_exp[a+1] & 16'hFF3F) | exp_reg2(d);
            end
        end
    endtask

    function automatic int ram_diffs();
        int c = 0;
        for (int i = 0; i < 64; i++)
            if (ram[i] !== ram_exp[i]) c++;
        return c;
    endfunction

    task automatic load_ram_now();
        for (int i = 0; i < 64; i++) ram_exp[i] = ram_init[i];
        load_ram = 1'b1;
        @(negedge refclk);
        load_ram = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [27:0] div);
        int w = 0;
        @(negedge refclk);
        while (!cfg_ready && w < 5000) begin
            @(negedge refclk);
            w++;
        end
        if (!cfg_ready) checkOutput("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        cfg_en    = en;
        cfg_div   = div;
        cfg_valid = 1'b1;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_result(input int max_cycles, output logic saw_done, output logic saw_err,
                               output int n);
        saw_done = 1'b0;
        saw_err  = 1'b0;
        n = 0;
        while (!saw_done && !saw_err && n < max_cycles) begin
            @(negedge refclk);
            n++;
            saw_done = done;
            saw_err  = err;
        end
    endtask

    task automatic wait_rst_release(input string tag);
        int n = 0;
        while (pll_rst && n < 200) begin
            @(negedge refclk);
            n++;
        end
        checkOutput(tag, 32'(n), 32'(RST_HOLD));
    endtask

    task automatic run_request(input string tag, input logic [3:0] en, input logic [27:0] div);
        logic bad, sd, se;
        int ens, n, den0;
        bad = 1'b0;
        ens = 0;
        for (int i = 0; i < NUM_OUT; i++)
            if (en[i]) begin
                ens++;
                if (div[7*i +: 7] == 7'd0) bad = 1'b1;
            end
        den0 = den_count;
        applyStimulus(en, div);
        wait_result(LOCK_TO + 400, sd, se, n);
        if (bad) begin
            checkOutput({tag, "_err"}, 32'(se), 32'd1);
            checkOutput({tag, "_den"}, 32'(den_count - den0), 32'd0);
            checkOutput({tag, "_ram"}, 32'(ram_diffs()), 32'd0);
        end else begin
            model_apply(en, div);
            checkOutput({tag, "_done"}, 32'(sd), 32'd1);
            checkOutput({tag, "_den"}, 32'(den_count - den0), 32'(4 * ens));
            checkOutput({tag, "_ram"}, 32'(ram_diffs()), 32'd0);
            checkOutput({tag, "_locked_ok"}, 32'(pll_locked_ok), 32'd1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_locked_ok"}, 32'(pll_locked_ok), 32'd0);
        checkOutput({tag, "_den"}, 32'(den), 32'd0);
        checkOutput({tag, "_dwe"}, 32'(dwe), 32'd0);
        checkOutput({tag, "_daddr"}, 32'(daddr), 32'd0);
        checkOutput({tag, "_di"}, 32'(di), 32'd0);
    endtask

    initial begin
        logic sd, se;
        int n, den0, w;
        logic [3:0]  ren;
        logic [27:0] rdiv;

        // Power-on
        for (int i = 0; i < 64; i++) ram_init[i] = 16'h0000;
        load_ram_now();
        repeat (2) @(negedge refclk);
        check_reset_values("por");
        rst = 1'b0;
        wait_rst_release("por_rst_hold");
        wait_result(400, sd, se, n);
        checkOutput("por_done", 32'(sd), 32'd1);
        checkOutput("por_no_drp", 32'(den_count), 32'd0);
        checkOutput("por_locked_ok", 32'(pll_locked_ok), 32'd1);

        // Single output, divide 40, keep bits all ones
        for (int i = 0; i < 64; i++) ram_init[i] = 16'($urandom);
        ram_init[8'h0A] = 16'hFFFF;
        ram_init[8'h0B] = 16'hFFFF;
        load_ram_now();
        run_request("div40", 4'b0010, {7'd0, 7'd0, 7'd40, 7'd0});
        checkOutput("div40_reg1", 32'(ram[8'h0A]), 32'h0000F514);
        checkOutput("div40_reg2", 32'(ram[8'h0B]), 32'h0000FF3F);

        // Odd and unity divides
        for (int i = 0; i < 64; i++) ram_init[i] = 16'h0000;
        load_ram_now();
        run_request("odd_unity", 4'b1001, {7'd7, 7'd0, 7'd0, 7'd1});
        checkOutput("unity_reg1", 32'(ram[8'h08]), 32'h00000041);
        checkOutput("unity_reg2", 32'(ram[8'h09]), 32'h00000040);
        checkOutput("div7_reg1", 32'(ram[8'h0E]), 32'h000000C4);
        checkOutput("div7_reg2", 32'(ram[8'h0F]), 32'h00000080);

        // Rejected zero divide
        den0 = den_count;
        applyStimulus(4'b0100, {7'd5, 7'd0, 7'd9, 7'd3});
        wait_result(20, sd, se, n);
        checkOutput("zero_err", 32'(se), 32'd1);
        checkOutput("zero_err_latency_ok", 32'(n <= 2), 32'd1);
        checkOutput("zero_no_den", 32'(den_count - den0), 32'd0);
        checkOutput("zero_pll_rst", 32'(pll_rst), 32'd0);

        // drdy withheld
        drdy_enable = 1'b0;
        applyStimulus(4'b0001, {7'd0, 7'd0, 7'd0, 7'd5});
        wait_result(300, sd, se, n);
        checkOutput("drdy_to_err", 32'(se), 32'd1);
        checkOutput("drdy_to_window", 32'(n >= DRDY_TIMEOUT && n <= DRDY_TIMEOUT + 6), 32'd1);
        checkOutput("drdy_to_pll_rst", 32'(pll_rst), 32'd1);
        checkOutput("drdy_to_locked_ok", 32'(pll_locked_ok), 32'd0);
        drdy_enable = 1'b1;
        repeat (4) @(negedge refclk);
        run_request("after_drdy_to", 4'b0101, {7'd0, 7'd12, 7'd0, 7'd127});

        // Lock withheld
        lock_enable = 1'b0;
        model_apply(4'b1000, {7'd3, 7'd0, 7'd0, 7'd0});
        applyStimulus(4'b1000, {7'd3, 7'd0, 7'd0, 7'd0});
        wait_result(LOCK_TO + 600, sd, se, n);
        checkOutput("lock_to_err", 32'(se), 32'd1);
        checkOutput("lock_to_pll_rst", 32'(pll_rst), 32'd1);
        checkOutput("lock_to_locked_ok", 32'(pll_locked_ok), 32'd0);
        checkOutput("lock_to_ram", 32'(ram_diffs()), 32'd0);
        lock_enable = 1'b1;
        applyStimulus(4'b0000, 28'h0);
        wait_result(600, sd, se, n);
        checkOutput("rerun_done", 32'(sd), 32'd1);
        checkOutput("rerun_reset_seq", 32'(n > RST_HOLD), 32'd1);
        checkOutput("rerun_locked_ok", 32'(pll_locked_ok), 32'd1);

        // rst mid-RD_WAIT
        applyStimulus(4'b0001, {7'd0, 7'd0, 7'd0, 7'd9});
        w = 0;
        while (!den && w < 50) begin
            @(negedge refclk);
            w++;
        end
        checkOutput("mid_rst_den_seen", 32'(den), 32'd1);
        @(posedge refclk);
        #2;
        checkOutput("mid_rst_rdwait_addr", 32'(daddr), 32'h08);
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge refclk);
        rst = 1'b0;
        wait_rst_release("mid_rst_hold");
        wait_result(400, sd, se, n);
        checkOutput("mid_rst_done", 32'(sd), 32'd1);
        checkOutput("mid_rst_locked_ok", 32'(pll_locked_ok), 32'd1);

        // Randomized requests against the reference model
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 64; i++) ram_init[i] = 16'($urandom);
                for (int i = 0; i < 64; i++) ram_exp[i] = ram_init[i];
                load_ram = 1'b1;
                @(negedge refclk);
                load_ram = 1'b0;
            end
            ren = 4'($urandom_range(0, 15));
            for (int i = 0; i < NUM_OUT; i++) rdiv[7*i +: 7] = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 5) == 0) rdiv[7*$urandom_range(0, 3) +: 7] = 7'd0;
            run_request($sformatf("rand%0d", it), ren, rdiv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
